shift_unit_pipe: RTL and testbench
==================================

// Module: shift_unit_pipe
// PURPOSE
//  Parametrised multi-mode barrel shifter for the pipelined MIPS datapath (EX stage and iterative units).
//  Supports SLL/SRL/SRA/ROR on a WIDTH-bit operand.
//  Implemented as log2(WIDTH) mux levels with optional per-level registers.
//  Valid/ready handshake on both sides gives full backpressure.
// PARAMETERS
//  WIDTH      32   operand width; power of two, >= 8
//  SHW        $clog2(WIDTH)   shift-amount width (localparam, derived; not overridable)
//  PIPELINED  0    0: all levels combinational, one output register (latency 1)
//                  1: register after every level (latency SHW)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      input operand valid
//  in_ready    out  1      unit accepts input this cycle
//  in_data     in   WIDTH  operand (dataA)
//  in_shamt    in   SHW    shift amount (dataB)
//  in_op       in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_data    out  WIDTH  shifted result
//  out_zero    out  1      [SHIFTER_FLAGS_EN only] out_data == 0
//  out_carry   out  1      [SHIFTER_FLAGS_EN only] last bit shifted out
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valids, out_valid, out_data and flags clear to 0 immediately.
//    In-flight ops are discarded. First acceptance is possible on the first clk edge after rst_n rises.
//  - Global advance: adv = !out_valid || out_ready.
//    in_ready = adv; it depends combinationally on out_ready.
//  - Transfer: accept when in_valid && in_ready.
//    Every stage register (data, shamt, op, valid, sign) loads from the previous stage when adv=1 and holds when adv=0.
//    Bubbles are not collapsed.
//  - Latency: result appears exactly 1 (PIPELINED=0) or SHW (PIPELINED=1) advancing edges after acceptance.
//    Throughput is 1 op/cycle with out_ready held 1.
//  - Ordering: results leave in acceptance order; out_data stays stable while out_valid && !out_ready.
//  - Level k (k=0..SHW-1) shifts by 2^k when shamt[k]=1:
//    - SLL: zero fill at LSBs.
//    - SRL: zero fill at MSBs.
//    - SRA: fill with the sign bit of the ORIGINAL operand, carried down the pipe.
//    - ROR: bits shifted out at the LSB wrap to the MSB.
//  - Boundaries:
//    - shamt=0 -> out_data=in_data for every op.
//    - shamt=WIDTH-1 is the maximum; no shift amount of WIDTH or more exists.
//    - SRA of a negative operand by WIDTH-1 -> all ones.
//    - ROR by any amount preserves popcount.
//  - Simultaneous accept and drain in the same cycle is legal and loses nothing.
// CONFIGURATION
//  SHIFTER_FLAGS_EN defined:
//    - out_zero and out_carry are ports, registered alongside out_data.
//    - carry: SLL -> in_data[WIDTH-shamt]; SRL/SRA -> in_data[shamt-1]; ROR -> out_data[WIDTH-1].
//    - carry is 0 when shamt=0.
//  SHIFTER_FLAGS_EN not defined: out_zero and out_carry and their logic do not exist; the port list ends at out_data.
// STRUCTURE
//  - shifter_pkg: op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11,
//    plus the constant SH_OP_W=2.
//  - Sub-module shift_level (params WIDTH, DIST):
//    - one combinational mux level: (data, en, op, sign, carry_in) -> (data, carry_out).
//    - shift_unit_pipe instantiates SHW of them via generate; a register slice follows each level when PIPELINED=1.
// TESTING (run at PIPELINED=0 and 1, with and without SHIFTER_FLAGS_EN)
//  1. SLL 0x0000_0001 by 31 -> 0x8000_0000; carry=0, zero=0.
//     SLL 0x8000_0001 by 1 -> 0x0000_0002; carry=1.
//  2. SRA 0x8000_0000 by 4 -> 0xF800_0000. SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF.
//     SRL 0x8000_0000 by 4 -> 0x0800_0000.
//  3. ROR 0x0000_00F1 by 4 -> 0x1000_000F; carry=0. ROR 0x1234_5678 by 0 -> 0x1234_5678.
//  4. Backpressure: stream 8 random ops with out_ready toggled 1,0,0,1,...
//     -> results in order, bit-exact vs reference model; out_data stable while stalled.
//  5. rst_n pulsed low mid-stream with 3 ops in flight -> out_valid=0 at once, no stale result after release.
//     Next op's result arrives after the nominal latency.
//  6. in_valid=1 and out_ready=1 held for 100 cycles -> one result per cycle after the initial latency.
//     SLL 0xFFFF_FFFF by 0 gives zero=0; SRL 0x1 by 1 gives 0 with zero=1.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel shifter: operation encodings and op field width.
package shifter_pkg;

  localparam int SH_OP_W = 2;

  typedef enum logic [SH_OP_W-1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

endpackage

// File: rtl/shift_level.sv
// One combinational mux level of the barrel shifter: shifts by DIST when en is set.
// Carry tracking exists only when SHIFTER_FLAGS_EN is defined.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0]   src,
  input  logic               en,
  input  logic [SH_OP_W-1:0] op,
  input  logic               sign,
`ifdef SHIFTER_FLAGS_EN
  input  logic               carry_prev,
  output logic               carry_next,
`endif
  output logic [WIDTH-1:0]   res
);

  always_comb begin
    res = src;
    if (en) begin
      case (sh_op_e'(op))
        SH_SLL:  res = {src[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_SRL:  res = {{DIST{1'b0}}, src[WIDTH-1:DIST]};
        SH_SRA:  res = {{DIST{sign}}, src[WIDTH-1:DIST]};
        default: res = {src[DIST-1:0], src[WIDTH-1:DIST]};
      endcase
    end
  end

`ifdef SHIFTER_FLAGS_EN
  // The last enabled level decides the carry; for ROR it equals the result MSB.
  always_comb begin
    carry_next = carry_prev;
    if (en) begin
      case (sh_op_e'(op))
        SH_SLL:  carry_next = src[WIDTH-DIST];
        default: carry_next = src[DIST-1];
      endcase
    end
  end
`endif

endmodule

// File: rtl/shift_unit_pipe.sv
// Multi-mode barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and optional per-level registers.
// Optional zero/carry flag outputs are enabled by defining SHIFTER_FLAGS_EN.
module shift_unit_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit PIPELINED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [SH_OP_W-1:0]       in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic                     out_zero,
  output logic                     out_carry
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic                 adv;
  logic [WIDTH-1:0]     data_s  [SHW+1];
  logic                 vld_s   [SHW+1];
  logic [SHW-1:0]       shamt_s [SHW];
  logic [SH_OP_W-1:0]   op_s    [SHW];
  logic                 sign_s  [SHW];
`ifdef SHIFTER_FLAGS_EN
  logic                 carry_s [SHW+1];
  assign carry_s[0] = 1'b0;
`endif

  // The whole pipe moves in lockstep; bubbles are kept, so the output register gates everything.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign data_s[0]  = in_data;
  assign vld_s[0]   = in_valid;
  assign shamt_s[0] = in_shamt;
  assign op_s[0]    = in_op;
  assign sign_s[0]  = in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    logic [WIDTH-1:0] lvl_data;
`ifdef SHIFTER_FLAGS_EN
    logic             lvl_carry;
`endif

    shift_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
      .src        (data_s[k]),
      .en         (shamt_s[k][k]),
      .op         (op_s[k]),
      .sign       (sign_s[k]),
`ifdef SHIFTER_FLAGS_EN
      .carry_prev (carry_s[k]),
      .carry_next (lvl_carry),
`endif
      .res        (lvl_data)
    );

    // Stage boundary after level k (always present after the last level)
    if (PIPELINED || k == SHW-1) begin : g_reg
      logic [WIDTH-1:0] data_p;
      logic             vld_p;
`ifdef SHIFTER_FLAGS_EN
      logic             carry_p;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_p <= '0;
          vld_p  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
          carry_p <= 1'b0;
`endif
        end else if (adv) begin
          data_p <= lvl_data;
          vld_p  <= vld_s[k];
`ifdef SHIFTER_FLAGS_EN
          carry_p <= lvl_carry;
`endif
        end
      end
      assign data_s[k+1] = data_p;
      assign vld_s[k+1]  = vld_p;
`ifdef SHIFTER_FLAGS_EN
      assign carry_s[k+1] = carry_p;
`endif
    end else begin : g_comb
      assign data_s[k+1] = lvl_data;
      assign vld_s[k+1]  = vld_s[k];
`ifdef SHIFTER_FLAGS_EN
      assign carry_s[k+1] = lvl_carry;
`endif
    end

    if (k < SHW-1) begin : g_side
      if (PIPELINED) begin : g_side_reg
        logic [SHW-1:0]     shamt_p;
        logic [SH_OP_W-1:0] op_p;
        logic               sign_p;
        always_ff @(posedge clk) begin
          if (adv) begin
            shamt_p <= shamt_s[k];
            op_p    <= op_s[k];
            sign_p  <= sign_s[k];
          end
        end
        assign shamt_s[k+1] = shamt_p;
        assign op_s[k+1]    = op_p;
        assign sign_s[k+1]  = sign_p;
      end else begin : g_side_comb
        assign shamt_s[k+1] = shamt_s[k];
        assign op_s[k+1]    = op_s[k];
        assign sign_s[k+1]  = sign_s[k];
      end
    end

`ifdef SHIFTER_FLAGS_EN
    if (k == SHW-1) begin : g_zero
      logic zero_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   zero_p <= 1'b0;
        else if (adv) zero_p <= (lvl_data == '0);
      end
      assign out_zero = zero_p;
    end
`endif
  end

  assign out_valid = vld_s[SHW];
  assign out_data  = data_s[SHW];
`ifdef SHIFTER_FLAGS_EN
  assign out_carry = carry_s[SHW];
`endif

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed-vector bench for shift_unit_pipe (WIDTH=32); flag checks follow SHIFTER_FLAGS_EN.
module tb_shift_unit_pipe;

  parameter int PIPELINED = 0;
  localparam int LAT = (PIPELINED != 0) ? 5 : 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef SHIFTER_FLAGS_EN
  logic        out_zero;
  logic        out_carry;
`endif

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(32), .PIPELINED(PIPELINED != 0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFTER_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] r;
    logic        z;
    logic        c;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] r;
    logic        z;
    logic        c;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        dv[14];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          next_id  = 0;
  logic        bp_en    = 1'b0;
  logic [3:0]  bp_pat   = 4'b1001;
  int          bp_idx   = 0;
  logic        stalled  = 1'b0;
  logic [31:0] held     = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    case (op)
      2'b00:   model_res = d << s;
      2'b01:   model_res = d >> s;
      2'b10:   model_res = $unsigned($signed(d) >>> s);
      default: model_res = (d >> s) | (d << (32 - int'(s)));
    endcase
  endfunction

  function automatic logic model_carry(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    logic [31:0] r;
    r = model_res(d, s, op);
    if (s == 5'd0)      model_carry = 1'b0;
    else if (op == 2'b00) model_carry = d[32 - int'(s)];
    else if (op == 2'b11) model_carry = r[31];
    else                model_carry = d[int'(s) - 1];
  endfunction

  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                      input logic [31:0] r, input logic z, input logic c);
    int   w;
    exp_t e;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 200);
    if (!in_ready) begin
      check_eq("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.id = next_id;
      e.r  = r;
      e.z  = z;
      e.c  = c;
      next_id++;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] r;
    d  = $urandom;
    s  = 5'($urandom_range(0, 31));
    op = 2'($urandom_range(0, 3));
    r  = model_res(d, s, op);
    send(d, s, op, r, (r == 32'd0), model_carry(d, s, op));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output ready: held high, or cycling 1,0,0,1 when backpressure is enabled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = bp_pat[bp_idx];
        bp_idx    = (bp_idx + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Scoreboard and stall-stability monitor
  always @(negedge clk) begin
    if (stalled && out_valid)
      check_eq("stall_hold", out_data, held);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq($sformatf("data#%0d", mon_e.id), out_data, mon_e.r);
`ifdef SHIFTER_FLAGS_EN
        check_eq($sformatf("zero#%0d", mon_e.id), 32'(out_zero), 32'(mon_e.z));
        check_eq($sformatf("carry#%0d", mon_e.id), 32'(out_carry), 32'(mon_e.c));
`endif
      end
    end
    if (out_valid && !out_ready) begin
      held    = out_data;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int cnt;
    int w;

    dv[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0, 1'b0};
    dv[1]  = '{32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002, 1'b0, 1'b1};
    dv[2]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0, 1'b0};
    dv[3]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0};
    dv[4]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1'b0, 1'b0};
    dv[5]  = '{32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F, 1'b0, 1'b0};
    dv[6]  = '{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1'b0, 1'b0};
    dv[7]  = '{32'hFFFF_FFFF, 5'd0,  2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0};
    dv[8]  = '{32'h0000_0001, 5'd1,  2'b01, 32'h0000_0000, 1'b1, 1'b1};
    dv[9]  = '{32'h8000_0001, 5'd1,  2'b11, 32'hC000_0000, 1'b0, 1'b1};
    dv[10] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b1, 1'b1};
    dv[11] = '{32'h0000_000F, 5'd3,  2'b01, 32'h0000_0001, 1'b0, 1'b1};
    dv[12] = '{32'h0000_0003, 5'd30, 2'b00, 32'hC000_0000, 1'b0, 1'b0};
    dv[13] = '{32'hF000_0000, 5'd0,  2'b10, 32'hF000_0000, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_shamt = '0;
    in_op    = '0;

    #3;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_FLAGS_EN
    check_eq("rst_zero", 32'(out_zero), 32'd0);
    check_eq("rst_carry", 32'(out_carry), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back
    for (int i = 0; i < 14; i++)
      send(dv[i].d, dv[i].s, dv[i].op, dv[i].r, dv[i].z, dv[i].c);
    drain();

    // Backpressure stream
    bp_en = 1'b1;
    repeat (8) send_rand();
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with ops in flight
    repeat (3) send_rand();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_data", out_data, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check_eq("latency", 32'(lat), 32'(LAT));
    drain();

    // Sustained throughput
    fork
      begin
        repeat (100) send_rand();
      end
      begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 50);
        cnt = (out_valid && out_ready) ? 1 : 0;
        repeat (99) begin
          @(negedge clk);
          if (out_valid && out_ready) cnt++;
        end
        check_eq("throughput", 32'(cnt), 32'd100);
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
